// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
//   BCD_DIGIT_W  width of one BCD digit
//   BCD_MAX      largest legal digit value
//   BCD_ADJ      decimal correction added to an overflowing binary digit sum
//   bcd_ctrl_state_t  sequencer states
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned BCD_MAX     = 9;
   localparam int unsigned BCD_ADJ     = 6;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } bcd_ctrl_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder, purely combinational.
// Ports:
//   a_d_i, b_d_i  operand digits (non-BCD values pass through the same formula)
//   c_in_i        decimal carry-in
//   s_d_o         result digit
//   c_out_o       decimal carry-out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a_d_i,
   input  logic [3:0] b_d_i,
   input  logic       c_in_i,
   output logic [3:0] s_d_o,
   output logic       c_out_o
);

   logic [4:0] t;

   always_comb begin
      t = {1'b0, a_d_i} + {1'b0, b_d_i} + {4'b0000, c_in_i};
      if (t > 5'(BCD_MAX)) begin
         // Only the low nibble of (t + 6) is kept; the carry is implied by t > 9.
         s_d_o   = t[3:0] + 4'(BCD_ADJ);
         c_out_o = 1'b1;
      end else begin
         s_d_o   = t[3:0];
         c_out_o = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial N-digit packed-BCD adder: one shared digit adder walks the operands
// from LS to MS digit, one digit per clock, with the decimal carry held in a register.
// Optional build macro: BCD_ERR_EN adds err_o, a sticky flag for non-BCD operand digits.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid_i / in_ready_o   operand handshake (in_ready_o high only in IDLE)
//   a_i, b_i, cin_i           packed BCD operands (digit 0 in [3:0]) and carry-in
//   out_valid_o / out_ready_i result handshake (out_valid_o high only in DONE)
//   sum_o, cout_o             packed BCD result and decimal carry-out
//   err_o                     (BCD_ERR_EN only) non-BCD digit seen, valid with out_valid_o
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [4*N-1:0] a_i,
   input  logic [4*N-1:0] b_i,
   input  logic           cin_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [4*N-1:0] sum_o,
   output logic           cout_o
`ifdef BCD_ERR_EN
   ,
   output logic           err_o
`endif
);

   localparam int unsigned W = BCD_DIGIT_W * N;

   bcd_ctrl_state_t state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic            carry_q, carry_d, cout_q, cout_d;
   logic [3:0]      dig_s;
   logic            dig_c;
   logic            accept, last_digit;

   assign accept     = (state_q == IDLE) && in_valid_i;
   assign last_digit = (idx_q == IDX_W'(N - 1));

   bcd_digit_add u_digit_add (
      .a_d_i  (a_q[3:0]),
      .b_d_i  (b_q[3:0]),
      .c_in_i (carry_q),
      .s_d_o  (dig_s),
      .c_out_o(dig_c)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid_i)  state_d = RUN;
         RUN:     if (last_digit)  state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode the state only
   always_comb begin
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
   end

   // Datapath next-state
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      if (accept) begin
         a_d     = a_i;
         b_d     = b_i;
         carry_d = cin_i;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         a_d     = a_q >> BCD_DIGIT_W;
         b_d     = b_q >> BCD_DIGIT_W;
         // New digit enters at the MS end so digit 0 lands in [3:0] after N steps.
         sum_d   = sum_q >> BCD_DIGIT_W;
         sum_d[W-1 -: BCD_DIGIT_W] = dig_s;
         carry_d = dig_c;
         idx_d   = idx_q + IDX_W'(1);
         if (last_digit) begin
            cout_d = dig_c;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;

`ifdef BCD_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = 1'b0;
      end else if (state_q == RUN) begin
         err_d = err_q | (a_q[3:0] > 4'(BCD_MAX)) | (b_q[3:0] > 4'(BCD_MAX));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (N = 4). Expected results come from a
// decimal-arithmetic model and are queued when operands are accepted.
module tb_bcd_serial_add_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef BCD_ERR_EN
   logic         err;
`endif

   int checks = 0;
   int errors = 0;
   logic [W:0] exp_q[$];

   always #5 clk = ~clk;

   bcd_serial_add_ctrl #(
      .N(N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .a_i        (a),
      .b_i        (b),
      .cin_i      (cin),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .sum_o      (sum),
      .cout_o     (cout)
`ifdef BCD_ERR_EN
      ,
      .err_o      (err)
`endif
   );

   function automatic int unsigned bcd2int(input logic [W-1:0] v);
      int unsigned r;
      r = 0;
      for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic cv);
      int unsigned s;
      int unsigned lim;
      logic        co;
      logic [W-1:0] r;
      s   = bcd2int(av) + bcd2int(bv) + int'(cv);
      lim = 1;
      for (int i = 0; i < N; i++) lim = lim * 10;
      co = (s >= lim);
      if (co) s = s - lim;
      for (int i = 0; i < N; i++) begin
         r[i*4 +: 4] = 4'(s % 10);
         s = s / 10;
      end
      return {co, r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair for a single accepting edge; optionally queue the model result.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input bit push);
      a = av;
      b = bv;
      cin = cv;
      in_valid = 1'b1;
      if (push) exp_q.push_back(model(av, bv, cv));
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b, need 1 0 0000 0",
                  in_ready, out_valid, sum, cout);
      end
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_add_table();
      logic [W-1:0] ta[3];
      logic [W-1:0] tb[3];
      logic         tc[3];
      logic [W:0]   tk[3];
      logic [W:0]   e;
      int           lat;
      ta[0] = 16'h1234; tb[0] = 16'h5678; tc[0] = 1'b0; tk[0] = {1'b0, 16'h6912};
      ta[1] = 16'h9999; tb[1] = 16'h0001; tc[1] = 1'b0; tk[1] = {1'b1, 16'h0000};
      ta[2] = 16'h9999; tb[2] = 16'h9999; tc[2] = 1'b1; tk[2] = {1'b1, 16'h9999};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_in_ready[%0d]: got %b need 1", i, in_ready);
         end
         send(ta[i], tb[i], tc[i], 1'b1);
         wait_out(lat);
         checks++;
         if (lat != N) begin
            errors++;
            $display("FAIL add_latency[%0d]: got %0d edges need %0d", i, lat, N);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         checks++;
         if ({cout, sum} !== e || e !== tk[i]) begin
            errors++;
            $display("FAIL add_result[%0d]: got cout=%b sum=%h need cout=%b sum=%h",
                     i, cout, sum, tk[i][W], tk[i][W-1:0]);
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_release[%0d]: got rdy=%b vld=%b need 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] e;
      int         lat;
      send(16'h2468, 16'h1357, 1'b0, 1'b1);
      wait_out(lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      in_valid = 1'b1;
      a = 16'h1111;
      b = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== e
             || e !== {1'b0, 16'h3825}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b cout=%b sum=%h need 1 0 0 3825",
                     i, out_valid, in_ready, cout, sum);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h3825) begin
         errors++;
         $display("FAIL bp_release: got rdy=%b vld=%b sum=%h need 1 0 3825",
                  in_ready, out_valid, sum);
      end
      // The 0x1111 pair offered during DONE must not have started a run.
      for (int i = 0; i < N + 1; i++) begin
         step();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_capture[%0d]: got rdy=%b vld=%b need 1 0",
                     i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oa[2];
      logic [W-1:0] ob[2];
      logic [W:0]   e;
      int           acc_cyc[$];
      int           sent;
      int           got;
      bit           acc;
      oa[0] = 16'h0999; ob[0] = 16'h0001;
      oa[1] = 16'h5000; ob[1] = 16'h5000;
      sent = 0;
      got = 0;
      a = oa[0];
      b = ob[0];
      cin = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 2; c++) begin
         acc = (in_valid === 1'b1) && (in_ready === 1'b1);
         if (acc) begin
            exp_q.push_back(model(a, b, cin));
            acc_cyc.push_back(c);
         end
         step();
         if (acc) begin
            sent++;
            if (sent < 2) begin
               a = oa[1];
               b = ob[1];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({cout, sum} !== e) begin
               errors++;
               $display("FAIL b2b_result[%0d]: got cout=%b sum=%h need cout=%b sum=%h",
                        got, cout, sum, e[W], e[W-1:0]);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (got != 2 || acc_cyc.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d results %0d accepts need 2 2", got, acc_cyc.size());
      end else begin
         checks++;
         if (acc_cyc[1] - acc_cyc[0] != N + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles need %0d", acc_cyc[1] - acc_cyc[0], N + 2);
         end
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      logic [W:0] e;
      int         lat;
      send(16'h4321, 16'h1111, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_run: got vld=%b sum=%h cout=%b rdy=%b need 0 0000 0 1",
                  out_valid, sum, cout, in_ready);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < N + 2; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_pulse[%0d]: got vld=%b rdy=%b need 0 1", i, out_valid, in_ready);
         end
      end
      send(16'h0005, 16'h0005, 1'b0, 1'b1);
      wait_out(lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      checks++;
      if (lat != N || {cout, sum} !== e || e !== {1'b0, 16'h0010}) begin
         errors++;
         $display("FAIL rst_recover: got lat=%0d cout=%b sum=%h need %0d 0 0010",
                  lat, cout, sum, N);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

`ifdef BCD_ERR_EN
   task automatic test_err();
      logic [W:0] e;
      int         lat;
      send(16'h00A0, 16'h0000, 1'b0, 1'b0);
      wait_out(lat);
      checks++;
      if (err !== 1'b1 || lat != N) begin
         errors++;
         $display("FAIL err_set: got err=%b lat=%0d need 1 %0d", err, lat, N);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      send(16'h0012, 16'h0034, 1'b0, 1'b1);
      wait_out(lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      checks++;
      if (err !== 1'b0 || {cout, sum} !== e) begin
         errors++;
         $display("FAIL err_clear: got err=%b sum=%h need 0 %h", err, sum, e[W-1:0]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add_table();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
`ifdef BCD_ERR_EN
      test_err();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial sequencer for N-digit packed-BCD addition that reuses one single-digit BCD adder across all digits.
- Accepts an operand pair over a valid/ready handshake.
- Steps the shared digit adder from LS digit to MS digit, one digit per clock, rippling the decimal carry through a register.
- Presents the result over a second valid/ready handshake.
- Area-optimised alternative to the fully parallel ripple BCD adder in the arithmetic datapath.

Parameters:
N, 4, number of BCD digits per operand (N >= 1)
IDX_W, $clog2(N) (min 1), width of the digit index counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block idle, can accept operands
a  input  4*N  packed BCD operand A, digit 0 in [3:0]
b  input  4*N  packed BCD operand B
cin  input  1  decimal carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  4*N  packed BCD result
cout  output  1  decimal carry-out

Behaviour:
- Reset is asynchronous, active-high, on clk domain: state=IDLE; out_valid=0; sum=0; cout=0; idx=0; carry reg=0; operand regs=0. in_ready=1 while in IDLE, including during reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded directly from state registers; no combinational path from in_valid/out_ready.
- IDLE -> RUN on in_valid&&in_ready: capture a, b into shift registers, cin into carry reg, idx=0.
- RUN, each cycle:
  - Digit adder takes the LS 4 bits of each operand shift reg plus the carry reg.
  - Result digit shifts into sum from the MS end (sum >> 4, new digit at [4N-1:4N-4]).
  - Carry reg takes the digit carry-out; operand regs shift right by 4; idx++.
  - When idx==N-1: go to DONE and load cout from the final digit carry.
- DONE holds sum/cout stable while out_valid=1 && out_ready=0, indefinitely. On out_ready=1: go to IDLE.
- Latency: out_valid rises exactly N clock edges after the accepting edge. Minimum issue interval is N+2 cycles. No same-cycle DONE->accept turnaround.
- Digit adder arithmetic, all unsigned:
  - t = a_d + b_d + c, 5 bits, range 0..19.
  - If t > 9: digit = (t+6)[3:0], carry=1.
  - Else: digit = t[3:0], carry=0.
- Non-BCD input digits (>9) are not rejected; the same formula applies and the result is don't-care-but-deterministic.
- in_valid during RUN/DONE is ignored; the operands are not captured.
- out_ready in IDLE/RUN is ignored.
- sum/cout keep their last result value in IDLE. During RUN they reflect the partial shift contents; consumers sample them only when out_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation immediately; no output pulse follows.
- N=1: RUN lasts one cycle.

Optional Feature:
BCD_ERR_EN
- Defined:
  - Adds output port err (1 bit).
  - A sticky flag clears on accept and sets in RUN if the current a_d > 9 or b_d > 9.
  - err drives the flag, is valid when out_valid=1, and resets to 0.
- Undefined: no err port and no checking logic; behaviour is otherwise identical.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_ADJ=6.
  - Enum typedef bcd_ctrl_state_t {IDLE, RUN, DONE}.
  - Typedef bcd_digit_t (logic [3:0]).
- One combinational sub-module, bcd_digit_add (a_d, b_d, c_in -> s_d, c_out), instantiated once and shared by the sequencer.

Test Plan:
- Basic add, N=4: a=0x1234, b=0x5678, cin=0 -> out_valid exactly 4 edges after accept; sum=0x6912, cout=0.
- Full carry ripple: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0, and a new in_valid with a=0x1111 is not captured. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two operand sets, out_ready=1 -> results in order; accepts spaced exactly N+2 cycles.
- Reset mid-RUN: assert rst at idx=2 -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. After release, 0x0005+0x0005 -> sum=0x0010, cout=0.
- BCD_ERR_EN only: a=0x00A0, b=0x0000 -> err=1 with out_valid. A following valid pair -> err=0.
